// File: rtl/multiplier_pkg.sv
// Shared widths and FSM state type for the sequential multiplier and its
// downstream modular reduction stage.
package multiplier_pkg;

    localparam int OP_WIDTH    = 16;
    localparam int DATA_LENGTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/coeff_mul_seq.sv
// Radix-2 shift-add unsigned multiplier with a fixed latency of OP_WIDTH+1 cycles.
// It produces one product per OP_WIDTH+2 cycles and feeds the reduction stage.
module coeff_mul_seq #(
    parameter int OP_WIDTH    = multiplier_pkg::OP_WIDTH,
    parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [OP_WIDTH-1:0]    a_i,
    input  logic [OP_WIDTH-1:0]    b_i,
    output logic [DATA_LENGTH-1:0] product_o,
    output logic                   valid_o,
    output logic                   busy_o
);
    import multiplier_pkg::*;

    localparam int ACC_W = 2 * OP_WIDTH;
    localparam int CNT_W = $clog2(OP_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_WIDTH - 1);

    if (DATA_LENGTH < 2 * OP_WIDTH) begin : g_width_check
        $error("coeff_mul_seq: DATA_LENGTH must be at least 2*OP_WIDTH");
    end

    state_e                   state_q, state_d;
    logic [ACC_W-1:0]         a_q, a_d;
    logic [OP_WIDTH-1:0]      b_q, b_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0]   product_q, product_d;
    logic [ACC_W-1:0]         acc_sum;

    // Next-state logic: operand latch in IDLE, one shift-add step per MUL cycle
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        // The accumulator is 2*OP_WIDTH wide, so this sum never wraps.
        acc_sum   = acc_q + (b_q[0] ? a_q : {ACC_W{1'b0}});

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = MUL;
                    a_d     = ACC_W'(a_i);
                    b_d     = b_i;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = acc_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    product_d = DATA_LENGTH'(acc_sum);
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            a_q       <= {ACC_W{1'b0}};
            b_q       <= {OP_WIDTH{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            product_q <= {DATA_LENGTH{1'b0}};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product_o = product_q;
    assign valid_o   = (state_q == DONE);
    assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/coeff_mul_seq.md
COEFF_MUL_SEQ -- requirements
Module: coeff_mul_seq

Interface
REQ-001 The block SHALL take parameter OP_WIDTH, default 16, which sets the operand width in bits.
REQ-002 The block SHALL take parameter DATA_LENGTH, default multiplier_pkg::DATA_LENGTH, which sets the product width in bits.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: request to begin a multiplication.
REQ-006 The block SHALL have port a_i, input, OP_WIDTH bits: operand a, unsigned.
REQ-007 The block SHALL have port b_i, input, OP_WIDTH bits: operand b, unsigned.
REQ-008 The block SHALL have port product_o, output, DATA_LENGTH bits: the product a*b, zero-extended; it drives x_i of the downstream reduction_top.
REQ-009 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse marking product_o valid; it drives start_i of reduction_top.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high while an operation is in flight.

Function
REQ-011 Elaboration SHALL fail if DATA_LENGTH < 2*OP_WIDTH.
REQ-012 The FSM SHALL have exactly three states: IDLE, MUL and DONE.
REQ-013 In IDLE, start_i=1 at a clock edge SHALL latch a_i and b_i, clear the accumulator and the counter, and move the FSM to MUL.
REQ-014 Each edge in MUL SHALL perform one radix-2 shift-add step: if b_reg[0] is 1, add a_reg to acc; then shift a_reg left by 1, shift b_reg right by 1, and increment cnt.
REQ-015 After the step where cnt equals OP_WIDTH-1, the FSM SHALL move to DONE and load product_o from the final accumulator value.
REQ-016 For start sampled at edge k, valid_o SHALL be high only between edges k+OP_WIDTH and k+OP_WIDTH+1, giving a fixed latency of OP_WIDTH+1 cycles independent of the operand values.
REQ-017 DONE SHALL return to IDLE unconditionally after one cycle.
REQ-018 valid_o SHALL be a Moore output, high only in DONE.
REQ-019 product_o SHALL hold its value from the DONE entry until the next DONE entry.
REQ-020 busy_o SHALL be high in MUL and DONE, and low in IDLE.
REQ-021 start_i SHALL be ignored in MUL and DONE: no re-latch, no restart, and no effect on the result.
REQ-022 The earliest next accept SHALL be the edge on which the FSM is in IDLE again; back-to-back operation therefore gives one result every OP_WIDTH+2 cycles.
REQ-023 Operand values 0 and the all-ones value SHALL need no special handling; the accumulator SHALL be 2*OP_WIDTH bits wide and SHALL never overflow.
REQ-024 The block SHALL have no backpressure; the consumer must accept the valid_o pulse.

Reset
REQ-025 rst_i=1 at an edge SHALL force state=IDLE and clear acc, cnt, a_reg, b_reg and product_o to 0, with valid_o=0 and busy_o=0, regardless of the current state.
REQ-026 A reset during MUL SHALL abort the operation with no valid_o pulse, and start_i on the same edge SHALL be ignored.
REQ-027 After reset is released, the first edge with start_i=1 SHALL be accepted normally.

Structure
REQ-028 OP_WIDTH default and the state enum typedef (IDLE/MUL/DONE) SHALL live in multiplier_pkg next to DATA_LENGTH.
REQ-029 The block SHALL be one flat module with no sub-module; the adder is inline.
REQ-030 The registers SHALL be one sequential process, with one combinational next-state process.

Verification
REQ-031 Scenario: a=3328, b=3328, start pulsed 1 cycle -> valid_o high exactly at cycle 17 after accept; product_o=0x00A90000 (11075584); busy_o high for 17 cycles.
REQ-032 Scenario: a=0xFFFF, b=0xFFFF -> product_o=0xFFFE0001; a=0, b=0x1234 -> product_o=0; a=1, b=1 -> product_o=1; all with identical latency.
REQ-033 Scenario: start held high continuously with a=2, b=3 -> one result (6) per 18 cycles; changing a_i/b_i mid-operation does not alter the result.
REQ-034 Scenario: rst_i asserted 5 cycles into MUL -> no valid_o pulse; product_o=0, busy_o=0 next cycle; the following start with a=7, b=9 yields 63.
REQ-035 Scenario: chain into reduction_top with m_i=3329 and a=b=3328 -> reduction result_o=1; with a=1234, b=2345 -> result_o=(1234*2345) mod 3329.
REQ-036 Scenario: a random regression of at least 1000 operand pairs SHALL be compared against a*b computed in the bench, with zero mismatches required.
